// File: rtl/arith_decrypt_core.sv
// arith_decrypt_core: byte-serial stream decryptor with a Galois-LFSR keystream.
//
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   ena               - gates acceptance of new ciphertext (pending output still drains)
//   key_in, key_we    - key byte and strobe; low byte first, then high byte
//   ct_data/valid/ready - ciphertext input handshake (ct_ready is combinational)
//   pt_data/valid/ready - registered plaintext output handshake
//   key_ok            - full key loaded, block running
//   byte_count        - bytes decrypted since the last key load (wrapping)
//
// Each accepted byte: pt = (ct ^ rotl8(k, ROT)) - k, where k = lfsr[7:0].
// The LFSR then advances one Galois step.
module arith_decrypt_core #(
    parameter logic [15:0] ZERO_SEED = 16'hACE1,
    parameter logic [15:0] TAPS      = 16'hB400,
    parameter int unsigned ROT       = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic [7:0]  key_in,
    input  logic        key_we,
    input  logic [7:0]  ct_data,
    input  logic        ct_valid,
    output logic        ct_ready,
    output logic [7:0]  pt_data,
    output logic        pt_valid,
    input  logic        pt_ready,
    output logic        key_ok,
    output logic [15:0] byte_count
);

    localparam int unsigned ROT_M = ROT % 8;

    typedef enum logic [1:0] {
        S_NOKEY   = 2'd0,
        S_KEYHALF = 2'd1,
        S_RUN     = 2'd2
    } state_e;

    state_e      state_q;
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic [7:0]  key_lo_q;
    logic [7:0]  pt_data_q;
    logic [7:0]  pt_data_d;
    logic        pt_valid_q;
    logic [15:0] byte_count_q;
    logic [15:0] seed;
    logic [7:0]  ks;
    logic        accept;

    // Left-rotate a byte by the configured amount.
    function automatic logic [7:0] rotl8(input logic [7:0] v);
        return 8'((v << ROT_M) | (v >> (8 - ROT_M)));
    endfunction

    assign key_ok   = (state_q == S_RUN);
    // Key strobes take priority: the ciphertext byte is not consumed that cycle.
    assign ct_ready = key_ok && ena && !key_we && (!pt_valid_q || pt_ready);
    assign accept   = ct_valid && ct_ready;

    assign ks        = lfsr_q[7:0];
    assign pt_data_d = 8'((ct_data ^ rotl8(ks)) - ks);
    assign lfsr_d    = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
    assign seed      = {key_in, key_lo_q};

    // Key-load FSM and output register with pass-through on pt_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_NOKEY;
            lfsr_q       <= 16'h0000;
            key_lo_q     <= 8'h00;
            pt_data_q    <= 8'h00;
            pt_valid_q   <= 1'b0;
            byte_count_q <= 16'h0000;
        end else begin
            if (pt_valid_q && pt_ready) begin
                pt_valid_q <= 1'b0;
            end
            if (accept) begin
                pt_data_q    <= pt_data_d;
                pt_valid_q   <= 1'b1;
                lfsr_q       <= lfsr_d;
                byte_count_q <= byte_count_q + 16'd1;
            end
            case (state_q)
                S_NOKEY: begin
                    if (key_we) begin
                        key_lo_q <= key_in;
                        state_q  <= S_KEYHALF;
                    end
                end
                S_KEYHALF: begin
                    if (key_we) begin
                        // An all-zero seed would lock the LFSR; substitute a fixed one.
                        lfsr_q       <= (seed == 16'h0000) ? ZERO_SEED : seed;
                        byte_count_q <= 16'h0000;
                        state_q      <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (key_we) begin
                        // Re-keying discards any pending plaintext.
                        key_lo_q   <= key_in;
                        pt_valid_q <= 1'b0;
                        state_q    <= S_KEYHALF;
                    end
                end
                default: state_q <= S_NOKEY;
            endcase
        end
    end

    assign pt_data    = pt_data_q;
    assign pt_valid   = pt_valid_q;
    assign byte_count = byte_count_q;

endmodule

// File: doc/arith_decrypt_core.md
Name: arith_decrypt_core

Overview:
- Byte-serial stream decryptor; inverse of the arithmetic/XOR keystream encryptor in the tt_um_arythcrypto datapath.
- Loads a 16-bit key as two bytes and generates a keystream from a Galois LFSR.
- Accepts ciphertext bytes on a valid/ready input and emits plaintext on a registered valid/ready output.
- Sits between the ui_in/uio_in byte path and uo_out in the receive-side top level.

Parameters:
- ZERO_SEED, 16'hACE1, seed substituted when the loaded key is 16'h0000.
- TAPS, 16'hB400, Galois feedback mask (x^16+x^14+x^13+x^11+1).
- ROT, 3, left-rotate amount applied to the keystream byte before the XOR.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  block enable; low blocks new ciphertext acceptance only.
- key_in  in  8  key byte.
- key_we  in  1  key byte strobe; first strobe = low byte, second = high byte.
- ct_data  in  8  ciphertext byte.
- ct_valid  in  1  ciphertext valid.
- ct_ready  out  1  ciphertext accepted when ct_valid && ct_ready.
- pt_data  out  8  plaintext byte (registered).
- pt_valid  out  1  plaintext valid.
- pt_ready  in  1  downstream accepts plaintext.
- key_ok  out  1  full key loaded, block running.
- byte_count  out  16  bytes decrypted since the last key load, wraps at 16'hFFFF.

Behaviour:
- Reset (async, rst_n=0): state=S_NOKEY, lfsr=16'h0000, key_lo=0, pt_data=8'h00, pt_valid=0, key_ok=0, byte_count=0, ct_ready=0.
- FSM S_NOKEY: key_we -> capture key_lo=key_in, go S_KEYHALF.
- FSM S_KEYHALF: key_we -> seed = {key_in,key_lo}; lfsr = seed, or ZERO_SEED if seed==0; byte_count=0; go S_RUN.
- FSM S_RUN: key_we -> capture key_lo, clear pt_valid (pending output discarded), go S_KEYHALF. key_we has priority over a same-cycle ct handshake; that ct byte is not consumed (ct_ready is forced 0 that cycle).
- key_ok = (state==S_RUN).
- ct_ready = key_ok && ena && !key_we && (!pt_valid || pt_ready). Combinational; single output register with pass-through on pt_ready.
- Keystream byte k = lfsr[7:0] at time of acceptance.
- On accept: pt_data <= (ct_data ^ rotl8(k,ROT)) - k, mod 256 with 8-bit wrap, no carry out. pt_valid <= 1. lfsr advances one step: if lfsr[0], lfsr <= (lfsr>>1)^TAPS, else lfsr <= lfsr>>1. byte_count++.
- Latency: 1 cycle, accept edge to pt_valid high.
- Throughput: 1 byte/cycle while pt_ready=1.
- pt_valid falls on pt_valid && pt_ready with no same-cycle accept. Simultaneous accept and drain keeps pt_valid=1 with the new data.
- pt_data/pt_valid hold stable while pt_valid && !pt_ready.
- ena=0: no new accepts; lfsr frozen; pending output still drains.
- Reset mid-stream: all state cleared, key must be reloaded.

Test Plan:
1. Reset, then key bytes 0x34, 0x12; key_ok=1 the cycle after the second key_we. Send ct 0xD4 then 0x8C with pt_ready=1 -> pt 0x41 then 0x42, each 1 cycle after accept; byte_count=2.
2. Key 0xFF, 0x00 (seed 0x00FF); ct 0xFB -> pt 0x05, exercising the wrap-around of the subtraction.
3. Key 0x00, 0x00 -> ZERO_SEED is used; ct 0xEE -> pt 0x00.
4. Key 0x1234; ct 0xD4 with pt_ready=0 for 3 cycles -> pt_valid=1 and pt_data=0x41 held, ct_ready=0; release pt_ready with ct 0x8C presented -> 0x42 follows back-to-back.
5. Key 0x1234; ena=0 with ct_valid=1 -> ct_ready=0, no lfsr step; ena=1 -> ct 0xD4 gives 0x41, confirming the keystream did not advance.
6. Stream running with pt_valid=1; pulse key_we (0x34) -> pt_valid=0, key_ok=0, ct_ready=0; pulse key_we (0x12) -> ct 0xD4 gives 0x41 and byte_count restarts at 1. Separately, assert rst_n=0 mid-stream -> all outputs at reset values immediately.
